// File: rtl/fft64_twiddle_r4.sv
// Twiddle-multiply stage for the 64-point radix-4 DIF FFT: legs b, c and d are rotated by
// W64^(m*k) through a three-stage pipeline; leg a passes through width-matched.
module fft64_twiddle_r4 #(
  parameter int unsigned DATA_WIDTH = 18,
  parameter int unsigned TW_WIDTH   = 16,  // at most 16: the ROM is held in Q1.15
  parameter int unsigned STAGE      = 0,
  parameter int unsigned OUT_WIDTH  = DATA_WIDTH + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [8*DATA_WIDTH-1:0] data_in,
  input  logic                    ctrl_in,
  output logic [8*OUT_WIDTH-1:0]  data_out,
  output logic                    ctrl_out,
  output logic                    valid_out
);
  localparam int unsigned DW = DATA_WIDTH;
  localparam int unsigned TW = TW_WIDTH;
  localparam int unsigned OW = OUT_WIDTH;
  localparam int unsigned PW = DW + TW;
  localparam int unsigned SW = PW + 1;
  localparam int          Sh = 16 - int'(TW);
  localparam logic signed [SW-1:0] Rnd = SW'(64'd1 << (TW - 2));

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  // sin(pi*n/32) in Q1.15 for the first quadrant
  function automatic logic [15:0] qsin(input logic [4:0] n);
    case (n)
      5'd0:    return 16'd0;
      5'd1:    return 16'd3212;
      5'd2:    return 16'd6393;
      5'd3:    return 16'd9512;
      5'd4:    return 16'd12540;
      5'd5:    return 16'd15447;
      5'd6:    return 16'd18205;
      5'd7:    return 16'd20788;
      5'd8:    return 16'd23170;
      5'd9:    return 16'd25330;
      5'd10:   return 16'd27246;
      5'd11:   return 16'd28899;
      5'd12:   return 16'd30274;
      5'd13:   return 16'd31357;
      5'd14:   return 16'd32138;
      5'd15:   return 16'd32610;
      default: return 16'd32768;
    endcase
  endfunction

  // sin(2*pi*e/64) rounded to TW bits; quarter-wave symmetry folds e onto the table
  function automatic logic signed [TW-1:0] tw_sin(input logic [5:0] e);
    logic [4:0]           n;
    logic [16:0]          mag;
    logic signed [TW-1:0] r;
    n   = e[4] ? 5'd16 - {1'b0, e[3:0]} : {1'b0, e[3:0]};
    mag = (17'(qsin(n)) << 1) + (17'd1 << Sh);
    r   = $signed(TW'(mag >> (Sh + 1)));
    return e[5] ? -r : r;
  endfunction

  state_e     state_q, state_d;
  logic [3:0] j_q, j_d, j_cur;
  logic       active;
  logic [5:0] m;
  logic [5:0] e_k [3];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      j_q     <= '0;
    end else begin
      state_q <= state_d;
      j_q     <= j_d;
    end
  end

  // j_q is the index of the butterfly presented in the current cycle
  always_comb begin
    state_d = state_q;
    j_d     = j_q;
    active  = 1'b0;
    j_cur   = j_q;
    if (ctrl_in) begin
      state_d = StRun;
      j_d     = 4'd1;
      active  = 1'b1;
      j_cur   = 4'd0;
    end else begin
      case (state_q)
        StRun: begin
          active = 1'b1;
          if (j_q == 4'd15) begin
            state_d = StIdle;
            j_d     = 4'd0;
          end else begin
            j_d = j_q + 4'd1;
          end
        end
        default: begin
          j_d   = 4'd0;
          j_cur = 4'd0;
        end
      endcase
    end
  end

  always_comb begin
    m = (STAGE == 0) ? {2'b00, j_cur} : {2'b00, j_cur[1:0], 2'b00};
    e_k[0] = m;
    e_k[1] = {m[4:0], 1'b0};
    e_k[2] = m + {m[4:0], 1'b0};
  end

  // Stage 1: inputs, path selects and registered ROM read
  logic [8*DW-1:0]      d1_q;
  logic                 v1_q, c1_q;
  logic                 ex1_q [3];
  logic [1:0]           rot1_q [3];
  logic signed [TW-1:0] cos1_q [3];
  logic signed [TW-1:0] sin1_q [3];

  always_ff @(posedge clk) begin
    if (rst) begin
      d1_q <= '0;
      v1_q <= 1'b0;
      c1_q <= 1'b0;
      for (int k = 0; k < 3; k++) begin
        ex1_q[k]  <= 1'b0;
        rot1_q[k] <= '0;
        cos1_q[k] <= '0;
        sin1_q[k] <= '0;
      end
    end else begin
      d1_q <= data_in;
      v1_q <= active;
      c1_q <= ctrl_in;
      for (int k = 0; k < 3; k++) begin
        ex1_q[k]  <= (e_k[k][3:0] == 4'd0);
        rot1_q[k] <= e_k[k][5:4];
        cos1_q[k] <= tw_sin(e_k[k] + 6'd16);
        sin1_q[k] <= tw_sin(e_k[k]);
      end
    end
  end

  logic signed [DW-1:0] x1 [4];
  logic signed [DW-1:0] y1 [4];
  logic signed [OW-1:0] xe [3];
  logic signed [OW-1:0] ye [3];
  logic signed [OW-1:0] exx_d [3];
  logic signed [OW-1:0] exy_d [3];

  // Exact rotations are formed at OW bits so negating the most-negative input cannot wrap
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      x1[i] = $signed(d1_q[(7 - 2 * i) * DW +: DW]);
      y1[i] = $signed(d1_q[(6 - 2 * i) * DW +: DW]);
    end
    for (int k = 0; k < 3; k++) begin
      xe[k] = OW'(x1[k + 1]);
      ye[k] = OW'(y1[k + 1]);
      case (rot1_q[k])
        2'd0:    begin exx_d[k] = xe[k];  exy_d[k] = ye[k];  end
        2'd1:    begin exx_d[k] = ye[k];  exy_d[k] = -xe[k]; end
        2'd2:    begin exx_d[k] = -xe[k]; exy_d[k] = -ye[k]; end
        default: begin exx_d[k] = -ye[k]; exy_d[k] = xe[k];  end
      endcase
    end
  end

  // Stage 2: partial products, with leg a and exact results delayed alongside
  logic signed [PW-1:0] pxc2_q [3];
  logic signed [PW-1:0] pys2_q [3];
  logic signed [PW-1:0] pyc2_q [3];
  logic signed [PW-1:0] pxs2_q [3];
  logic signed [OW-1:0] exx2_q [3];
  logic signed [OW-1:0] exy2_q [3];
  logic                 ex2_q  [3];
  logic signed [OW-1:0] xa2_q, ya2_q;
  logic                 v2_q, c2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      xa2_q <= '0;
      ya2_q <= '0;
      v2_q  <= 1'b0;
      c2_q  <= 1'b0;
      for (int k = 0; k < 3; k++) begin
        pxc2_q[k] <= '0;
        pys2_q[k] <= '0;
        pyc2_q[k] <= '0;
        pxs2_q[k] <= '0;
        exx2_q[k] <= '0;
        exy2_q[k] <= '0;
        ex2_q[k]  <= 1'b0;
      end
    end else begin
      xa2_q <= OW'(x1[0]);
      ya2_q <= OW'(y1[0]);
      v2_q  <= v1_q;
      c2_q  <= c1_q;
      for (int k = 0; k < 3; k++) begin
        pxc2_q[k] <= PW'(x1[k + 1]) * PW'(cos1_q[k]);
        pys2_q[k] <= PW'(y1[k + 1]) * PW'(sin1_q[k]);
        pyc2_q[k] <= PW'(y1[k + 1]) * PW'(cos1_q[k]);
        pxs2_q[k] <= PW'(x1[k + 1]) * PW'(sin1_q[k]);
        exx2_q[k] <= exx_d[k];
        exy2_q[k] <= exy_d[k];
        ex2_q[k]  <= ex1_q[k];
      end
    end
  end

  // Stage 3: sum, round half up, select path
  logic signed [SW-1:0] sre [3];
  logic signed [SW-1:0] sim [3];
  logic [8*OW-1:0]      dout_d;

  always_comb begin
    dout_d = '0;
    dout_d[7 * OW +: OW] = xa2_q;
    dout_d[6 * OW +: OW] = ya2_q;
    for (int k = 0; k < 3; k++) begin
      sre[k] = SW'(pxc2_q[k]) + SW'(pys2_q[k]) + Rnd;
      sim[k] = SW'(pyc2_q[k]) - SW'(pxs2_q[k]) + Rnd;
      dout_d[(5 - 2 * k) * OW +: OW] = ex2_q[k] ? exx2_q[k] : OW'(sre[k] >>> (TW - 1));
      dout_d[(4 - 2 * k) * OW +: OW] = ex2_q[k] ? exy2_q[k] : OW'(sim[k] >>> (TW - 1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_out  <= '0;
      ctrl_out  <= 1'b0;
      valid_out <= 1'b0;
    end else begin
      data_out  <= dout_d;
      ctrl_out  <= c2_q;
      valid_out <= v2_q;
    end
  end

endmodule

// File: tb/tb_fft64_twiddle_r4.sv
// Scoreboard bench for fft64_twiddle_r4: STAGE=0 and STAGE=1 instances share stimulus and
// are checked against a floating-point twiddle reference.
module tb_fft64_twiddle_r4;
  localparam real PI = 3.14159265358979323846;

  typedef struct {
    logic [151:0] data;
    bit           ctrl;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst, ctrl_in;
  logic [143:0] data_in;
  logic [151:0] data_out0, data_out1;
  logic         ctrl_out0, ctrl_out1, valid_out0, valid_out1;

  exp_t q [2][$];
  int   total = 0, bad = 0;
  int   vcnt [2] = '{0, 0};
  int   zc = 0, zc_len = 3;
  bit   mon_en = 1'b0;
  bit   inframe = 1'b0;
  int   jm = 0;

  always #5 clk = ~clk;

  fft64_twiddle_r4 #(.STAGE(0)) dut0 (
    .clk(clk), .rst(rst), .data_in(data_in), .ctrl_in(ctrl_in),
    .data_out(data_out0), .ctrl_out(ctrl_out0), .valid_out(valid_out0)
  );

  fft64_twiddle_r4 #(.STAGE(1)) dut1 (
    .clk(clk), .rst(rst), .data_in(data_in), .ctrl_in(ctrl_in),
    .data_out(data_out1), .ctrl_out(ctrl_out1), .valid_out(valid_out1)
  );

  task automatic chk(input string nm, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
    end
  endtask

  task automatic chk_v(input string nm, input logic [151:0] act, input logic [151:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic longint rnd(input real v);
    if (v >= 0.0) return longint'($rtoi(v + 0.5));
    return -longint'($rtoi(-v + 0.5));
  endfunction

  function automatic longint wd(input logic [151:0] v, input int i);
    logic [18:0] w;
    w = v[(7 - i) * 19 +: 19];
    return longint'($signed(w));
  endfunction

  // Rotation of (x + jy) by exp(-j*2*pi*e/64); quarter turns are exact, others use Q1.15
  function automatic logic [151:0] model(input int stage, input int j, input logic [143:0] d);
    logic [151:0] r;
    logic [17:0]  w;
    longint       x, y, xo, yo, ci, si;
    int           m, e;
    real          th;
    r = '0;
    m = (stage == 0) ? j : 4 * (j % 4);
    for (int k = 0; k < 4; k++) begin
      w = d[(7 - 2 * k) * 18 +: 18];
      x = longint'($signed(w));
      w = d[(6 - 2 * k) * 18 +: 18];
      y = longint'($signed(w));
      e = (m * k) % 64;
      th = 2.0 * PI * real'(e) / 64.0;
      if (e % 16 == 0) begin
        ci = rnd($cos(th));
        si = rnd($sin(th));
        xo = x * ci + y * si;
        yo = y * ci - x * si;
      end else begin
        ci = rnd(32768.0 * $cos(th));
        si = rnd(32768.0 * $sin(th));
        xo = (x * ci + y * si + 16384) >>> 15;
        yo = (y * ci - x * si + 16384) >>> 15;
      end
      r[(7 - 2 * k) * 19 +: 19] = 19'(xo);
      r[(6 - 2 * k) * 19 +: 19] = 19'(yo);
    end
    return r;
  endfunction

  task automatic model_step(input bit r, input bit c, input logic [143:0] d);
    bit push;
    push = 1'b0;
    if (r) begin
      inframe = 1'b0;
    end else if (c) begin
      inframe = 1'b1;
      jm = 0;
      push = 1'b1;
    end else if (inframe && jm < 15) begin
      jm++;
      push = 1'b1;
    end else begin
      inframe = 1'b0;
    end
    if (push) begin
      q[0].push_back('{data: model(0, jm, d), ctrl: c});
      q[1].push_back('{data: model(1, jm, d), ctrl: c});
    end
  endtask

  task automatic drive(input bit r, input bit c, input logic [143:0] d);
    rst = r;
    ctrl_in = c;
    data_in = d;
    model_step(r, c, d);
    @(posedge clk);
    #1;
    if (r) begin
      q[0].delete();
      q[1].delete();
      zc = zc_len;
    end else if (zc > 0) begin
      zc--;
    end
  endtask

  function automatic logic [17:0] rw();
    int unsigned s;
    s = $urandom_range(0, 7);
    if (s == 0) return 18'h20000;
    if (s == 1) return 18'h1FFFF;
    return 18'($urandom);
  endfunction

  function automatic logic [143:0] rnd_data();
    logic [143:0] r;
    for (int i = 0; i < 8; i++) r[i * 18 +: 18] = rw();
    return r;
  endfunction

  function automatic logic [143:0] pk(input int a, input int b, input int c, input int d,
                                      input int e, input int f, input int g, input int h);
    return {18'(a), 18'(b), 18'(c), 18'(d), 18'(e), 18'(f), 18'(g), 18'(h)};
  endfunction

  task automatic mon(input int id, input logic [151:0] dout, input bit cout, input bit vout);
    exp_t e;
    if (zc > 0) begin
      chk_v($sformatf("reset_data%0d", id), dout, '0);
      chk($sformatf("reset_ctrl_valid%0d", id), {cout, vout}, 0);
    end
    if (vout) begin
      vcnt[id]++;
      chk($sformatf("valid_expected%0d", id), q[id].size() != 0, 1);
      if (q[id].size() != 0) begin
        e = q[id].pop_front();
        chk_v($sformatf("data%0d", id), dout, e.data);
        chk($sformatf("ctrl%0d", id), cout, e.ctrl);
      end
    end else begin
      chk($sformatf("ctrl_without_valid%0d", id), cout, 0);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mon(0, data_out0, ctrl_out0, valid_out0);
      mon(1, data_out1, ctrl_out1, valid_out1);
    end
  end

  initial begin
    int v;
    rst = 1'b0;
    ctrl_in = 1'b0;
    data_in = '0;
    @(posedge clk);
    #1;

    // Reset with random data (and a ctrl_in that must be ignored)
    drive(1, 1, rnd_data());
    mon_en = 1'b1;
    drive(1, 0, rnd_data());
    repeat (3) drive(0, 0, '0);

    // Directed vectors: j=0 bypass, j=1 multiply (STAGE 0), j=2 exact rotation (STAGE 1)
    drive(0, 1, pk(0, 0, 1000, 0, -5, 7, 0, 0));
    drive(0, 0, pk(0, 0, 1000, 0, 0, 0, 0, 0));
    drive(0, 0, pk(0, 0, 0, 0, -131072, 5, 0, 0));
    fork
      drive(0, 0, '0);
      begin
        #3;
        chk("bypass_xb", wd(data_out0, 2), 1000);
        chk("bypass_yb", wd(data_out0, 3), 0);
        chk("bypass_xc", wd(data_out0, 4), -5);
        chk("bypass_yc", wd(data_out0, 5), 7);
        chk("bypass_ctrl", ctrl_out0, 1);
        chk("bypass_valid", valid_out0, 1);
      end
    join
    fork
      drive(0, 0, '0);
      begin
        #3;
        chk("mult_xb", wd(data_out0, 2), 995);
        chk("mult_yb", wd(data_out0, 3), -98);
      end
    join
    fork
      drive(0, 0, '0);
      begin
        #3;
        chk("exact_xc", wd(data_out1, 4), 5);
        chk("exact_yc", wd(data_out1, 5), 131072);
      end
    join
    repeat (14) drive(0, 0, '0);

    // Single frame followed by surplus data
    v = vcnt[0];
    drive(0, 1, rnd_data());
    repeat (20) drive(0, 0, rnd_data());
    repeat (4) drive(0, 0, '0);
    chk("frame_len", vcnt[0] - v, 16);

    // Restart at j=9
    v = vcnt[0];
    drive(0, 1, rnd_data());
    repeat (8) drive(0, 0, rnd_data());
    drive(0, 1, rnd_data());
    repeat (20) drive(0, 0, rnd_data());
    repeat (4) drive(0, 0, '0);
    chk("restart_len", vcnt[0] - v, 25);

    // Reset at j=7: j0..j4 have already emerged, j5/j6 are killed
    v = vcnt[0];
    drive(0, 1, rnd_data());
    repeat (6) drive(0, 0, rnd_data());
    zc_len = 8;
    drive(1, 0, rnd_data());
    repeat (8) drive(0, 0, '0);
    zc_len = 3;
    chk("mid_reset_valids", vcnt[0] - v, 5);

    // Random frames, restarts and resets
    for (int n = 0; n < 1500; n++) begin
      bit r, c;
      r = ($urandom_range(0, 249) == 0);
      c = ($urandom_range(0, 17) == 0);
      drive(r, c, rnd_data());
    end
    repeat (6) drive(0, 0, '0);
    chk("drain0", q[0].size(), 0);
    chk("drain1", q[1].size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
